multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS main controller: sequences shared ALU, unified memory, IR and register file over
//  FETCH/DECODE/EXEC/MEM/WB steps. Decodes R-type, LW, SW, BEQ, J, ADDI. Waits on a memory ready
//  handshake; abandons stalled accesses after a bounded wait. Consumed by the multi-cycle datapath top.
// PARAMETERS
//  WAIT_W      8    width of memory-wait counter
//  WAIT_LIMIT  255  max stall cycles per memory access (<= 2^WAIT_W-1); 0 disables timeout
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26]; valid from DECODE until next FETCH
//  mem_ready    in   1  memory completes current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU zero (branch)
//  IorD         out  1  memory address mux: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register load
//  MemtoReg     out  1  RF write data: 0=ALUOut, 1=MDR
//  RegDst       out  1  RF write addr: 0=rt, 1=rd
//  RegWrite     out  1  RF write enable
//  ALUSrcA      out  1  0=PC, 1=A reg
//  ALUSrcB      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=funct-decoded
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  state        out  4  current state encoding (debug)
//  instr_done   out  1  one-cycle pulse, final cycle of an instruction
//  illegal_op   out  1  one-cycle pulse, unsupported opcode in DECODE
//  mem_timeout  out  1  one-cycle pulse, memory wait hit WAIT_LIMIT
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9
//   ADDIEX=10 ADDIWB=11. Outputs combinational from state (+mem_ready where noted); unlisted = 0.
//  Reset: state<=FETCH, wait counter<=0; while reset high ALL outputs forced 0 (state shows 0).
//  FETCH: MemRead=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00; IRWrite=PCWrite=mem_ready;
//   ->DECODE on mem_ready, else hold.
//  DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00. opcode 000000->EXEC, 100011/101011->MEMADR,
//   000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH with illegal_op=1 (no write).
//  MEMADR: ALUSrcA=1 ALUSrcB=10 ALUOp=00; ->MEMRD if LW, ->MEMWR if SW.
//  MEMRD: MemRead=1 IorD=1; ->MEMWB on mem_ready, else hold.
//  MEMWB: RegWrite=1 MemtoReg=1 RegDst=0; instr_done=1; ->FETCH.
//  MEMWR: MemWrite=1 IorD=1; on mem_ready: instr_done=1, ->FETCH; else hold.
//  EXEC: ALUSrcA=1 ALUSrcB=00 ALUOp=10; ->ALUWB.  ALUWB: RegWrite=1 RegDst=1; instr_done; ->FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01; instr_done; ->FETCH.
//  JUMP: PCWrite=1 PCSource=10; instr_done; ->FETCH.
//  ADDIEX: ALUSrcA=1 ALUSrcB=10 ALUOp=00; ->ADDIWB.  ADDIWB: RegWrite=1 RegDst=0; instr_done; ->FETCH.
//  CPI at mem_ready=1: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4.
//  Wait counter: increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0; clears on any state
//   change or mem_ready=1. If WAIT_LIMIT!=0 and counter==WAIT_LIMIT-1 with mem_ready=0: mem_timeout=1,
//   ->FETCH next cycle, counter cleared, no IRWrite/PCWrite/RegWrite, no instr_done.
//  mem_ready and timeout in same cycle: mem_ready wins, no timeout.
//  opcode ignored outside DECODE/MEMADR; mem_ready ignored outside wait states.
//  Reset mid-instruction: aborts immediately; no RegWrite/MemWrite/PCWrite after reset edge.
// TESTING
//  mem_ready=1, opcode=000000 -> states 0,1,6,7; RegWrite+RegDst in cycle 4; instr_done once.
//  LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead/IorD=1 throughout, then MEMWB.
//  opcode=111111 in DECODE -> illegal_op pulse, next state FETCH, no RegWrite/PCWrite/MemWrite.
//  WAIT_LIMIT=4, mem_ready=0 in MEMWR -> mem_timeout on 4th stall cycle, then FETCH, instr_done never.
//  BEQ then J back-to-back -> 3 cycles each; PCWriteCond/PCSource=01, then PCWrite/PCSource=10.
//  reset asserted in EXEC -> all outputs 0 that cycle, FETCH next, ALUWB never entered.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main controller: steps the shared datapath through fetch/decode/execute,
// with a bounded wait on the memory ready handshake.
module multicycle_control_fsm #(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [WAIT_W-1:0] LIM_M1 = WAIT_W'(WAIT_LIMIT - 1);

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       done, illegal, timeout;
  } ctrl_t;

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wcnt;
  logic              waiting, timeout;
  ctrl_t             c;

  assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // mem_ready has priority: a completing access never times out
  assign timeout = (WAIT_LIMIT != 0) && waiting && !mem_ready && (wcnt == LIM_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      wcnt <= '0;
    end else begin
      cur <= nxt;
      if (!waiting || mem_ready || timeout || (nxt != cur)) wcnt <= '0;
      else                                                   wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if      (opcode == OP_LW) nxt = S_MEMRD;
        else if (opcode == OP_SW) nxt = S_MEMWR;
        else                      nxt = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB; else if (timeout) nxt = S_FETCH;
      S_MEMWR:  if (mem_ready || timeout) nxt = S_FETCH;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (cur)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = mem_ready;
        c.pcwrite = mem_ready;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        if (!(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI})) c.illegal = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.done     = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
        c.done     = mem_ready;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.done     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
        c.done        = 1'b1;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
        c.done     = 1'b1;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    c.timeout = timeout;
    if (reset) c = '0;
  end

  assign PCWrite     = c.pcwrite;
  assign PCWriteCond = c.pcwritecond;
  assign IorD        = c.iord;
  assign MemRead     = c.memread;
  assign MemWrite    = c.memwrite;
  assign IRWrite     = c.irwrite;
  assign MemtoReg    = c.memtoreg;
  assign RegDst      = c.regdst;
  assign RegWrite    = c.regwrite;
  assign ALUSrcA     = c.alusrca;
  assign ALUSrcB     = c.alusrcb;
  assign ALUOp       = c.aluop;
  assign PCSource    = c.pcsource;
  assign instr_done  = c.done;
  assign illegal_op  = c.illegal;
  assign mem_timeout = c.timeout;
  assign state       = reset ? 4'd0 : 4'(cur);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed cycle-by-cycle vectors for the multi-cycle controller, plus CPI sequences.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_W(8), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  // ctrl bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
  //                 RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
  localparam logic [15:0] Z    = 16'h0000;
  localparam logic [15:0] F1   = 16'b1001_0100_0001_0000;
  localparam logic [15:0] F0   = 16'b0001_0000_0001_0000;
  localparam logic [15:0] DEC  = 16'b0000_0000_0011_0000;
  localparam logic [15:0] MADR = 16'b0000_0000_0110_0000;
  localparam logic [15:0] MRD  = 16'b0011_0000_0000_0000;
  localparam logic [15:0] MWB  = 16'b0000_0010_1000_0000;
  localparam logic [15:0] MWR  = 16'b0010_1000_0000_0000;
  localparam logic [15:0] EXE  = 16'b0000_0000_0100_1000;
  localparam logic [15:0] AWB  = 16'b0000_0001_1000_0000;
  localparam logic [15:0] BR   = 16'b0100_0000_0100_0101;
  localparam logic [15:0] JMP  = 16'b1000_0000_0000_0010;
  localparam logic [15:0] IWB  = 16'b0000_0000_1000_0000;
  // flag order: instr_done illegal_op mem_timeout
  localparam logic [2:0] NF = 3'b000, DN = 3'b100, IL = 3'b010, TO = 3'b001;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [15:0] ctrl;
    logic [2:0] fl;
  } vec_t;

  vec_t tv[$];

  function automatic void add(logic rst, logic [5:0] op, logic rdy, logic [3:0] st,
                              logic [15:0] ctrl, logic [2:0] fl);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.fl = fl;
    tv.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [15:0] ctrl_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic run_instr(string name, logic [5:0] op, int exp_cpi);
    int  n = 0;
    int  dones = 0;
    bit  seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      reset = 1'b0; opcode = op; mem_ready = 1'b1;
      #1;
      n++;
      if (instr_done) begin dones++; seen = 1; end
      @(posedge clk); #1;
    end
    chk({name, "_cpi"}, 0, n, exp_cpi);
    chk({name, "_done"}, 0, dones, 1);
    chk({name, "_back_to_fetch"}, 0, state, 4'd0);
  endtask

  initial begin
    // reset
    add(1, 6'h00, 1, 0, Z, NF);
    add(1, 6'h00, 1, 0, Z, NF);
    // R-type
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h00, 1, 1, DEC, NF);
    add(0, 6'h00, 1, 6, EXE, NF);
    add(0, 6'h00, 1, 7, AWB, DN);
    // LW with three stall cycles in MEMRD
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h23, 1, 1, DEC, NF);
    add(0, 6'h23, 1, 2, MADR, NF);
    add(0, 6'h23, 0, 3, MRD, NF);
    add(0, 6'h23, 0, 3, MRD, NF);
    add(0, 6'h23, 0, 3, MRD, NF);
    add(0, 6'h23, 1, 3, MRD, NF);
    add(0, 6'h23, 1, 4, MWB, DN);
    // SW
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h2B, 1, 1, DEC, NF);
    add(0, 6'h2B, 1, 2, MADR, NF);
    add(0, 6'h2B, 1, 5, MWR, DN);
    // BEQ then J back-to-back
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h04, 1, 1, DEC, NF);
    add(0, 6'h04, 1, 8, BR, DN);
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h02, 1, 1, DEC, NF);
    add(0, 6'h02, 1, 9, JMP, DN);
    // ADDI, opcode junk in FETCH is ignored
    add(0, 6'h3F, 1, 0, F1, NF);
    add(0, 6'h08, 1, 1, DEC, NF);
    add(0, 6'h08, 1, 10, MADR, NF);
    add(0, 6'h08, 1, 11, IWB, DN);
    // illegal opcode
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h3F, 1, 1, DEC, IL);
    add(0, 6'h3F, 0, 0, F0, NF);
    // SW timing out in MEMWR on the 4th stall cycle
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h2B, 1, 1, DEC, NF);
    add(0, 6'h2B, 1, 2, MADR, NF);
    add(0, 6'h2B, 0, 5, MWR, NF);
    add(0, 6'h2B, 0, 5, MWR, NF);
    add(0, 6'h2B, 0, 5, MWR, NF);
    add(0, 6'h2B, 0, 5, MWR, TO);
    // FETCH stall: counter restarted after the timeout, then timeout in FETCH itself
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 0, 0, F0, TO);
    // ready on the would-be timeout cycle wins
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 0, 0, F0, NF);
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h02, 1, 1, DEC, NF);
    add(0, 6'h02, 1, 9, JMP, DN);
    // reset while in EXEC
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h00, 1, 1, DEC, NF);
    add(1, 6'h00, 1, 0, Z, NF);
    add(0, 6'h00, 1, 0, F1, NF);
    add(0, 6'h02, 1, 1, DEC, NF);
    add(0, 6'h02, 1, 9, JMP, DN);

    foreach (tv[i]) begin
      reset = tv[i].rst; opcode = tv[i].op; mem_ready = tv[i].rdy;
      #1;
      chk("state", i, state, tv[i].st);
      chk("ctrl", i, ctrl_now(), tv[i].ctrl);
      chk("flags", i, {instr_done, illegal_op, mem_timeout}, tv[i].fl);
      @(posedge clk); #1;
    end

    run_instr("rtype", 6'h00, 4);
    run_instr("lw", 6'h23, 5);
    run_instr("sw", 6'h2B, 4);
    run_instr("beq", 6'h04, 3);
    run_instr("j", 6'h02, 3);
    run_instr("addi", 6'h08, 4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
